// File: rtl/pmu_seq_gen.sv
// PMU test-line sequencer: DA_test1 pulse, DA_test2/DA_test3 spaced handshake, trim code on DA_test4.
// Latency: outputs change at the C_start edge; one sequence lasts N+G+2 cycles. No backpressure: C_start is ignored while busy.
// Optional feature: define PMU_SEQ_STATS_EN to add the saturating C_seq_cnt completion counter.
module pmu_seq_gen #(
    parameter int MIN_PULSE_CYC = 1001,
    parameter int MIN_GAP_CYC   = 3
) (
    input  logic        C_clk,
    input  logic        C_rst,
    input  logic        C_start,
    input  logic [15:0] C_pulse_len,
    input  logic [7:0]  C_gap_len,
    input  logic [3:0]  C_code,
    output logic        DA_test1,
    output logic        DA_test2,
    output logic        DA_test3,
    output logic [3:0]  DA_test4,
    output logic        C_busy,
    output logic        C_done
`ifdef PMU_SEQ_STATS_EN
    ,
    output logic [15:0] C_seq_cnt
`endif
);

    // Floors of at least one cycle keep the minus-one counter loads from wrapping.
    localparam int          MIN_P_I = (MIN_PULSE_CYC < 1) ? 1 : MIN_PULSE_CYC;
    localparam int          MIN_G_I = (MIN_GAP_CYC < 1) ? 1 : MIN_GAP_CYC;
    localparam logic [15:0] MIN_P   = 16'(MIN_P_I);
    localparam logic [15:0] MIN_G   = 16'(MIN_G_I);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] gap_m1_q, gap_m1_d;
    logic        t1_q, t1_d;
    logic        t2_q, t2_d;
    logic        t3_q, t3_d;
    logic [3:0]  t4_q, t4_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        enter_done;

    logic [15:0] pulse_eff;
    logic [15:0] gap_in;
    logic [15:0] gap_eff;

    assign pulse_eff = (C_pulse_len > MIN_P) ? C_pulse_len : MIN_P;
    assign gap_in    = {8'd0, C_gap_len};
    assign gap_eff   = (gap_in > MIN_G) ? gap_in : MIN_G;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_m1_d   = gap_m1_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        t3_d       = t3_q;
        t4_d       = t4_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        enter_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (C_start) begin
                    state_d  = PULSE;
                    cnt_d    = pulse_eff - 16'd1;
                    gap_m1_d = gap_eff - 16'd1;
                    t4_d     = C_code;
                    t1_d     = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == 16'd0) begin
                    // DA_test3 is still high here, so DA_test2 never rises against a low DA_test3.
                    state_d = GAP;
                    cnt_d   = gap_m1_q;
                    t1_d    = 1'b0;
                    t2_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == 16'd0) begin
                    state_d    = DONE;
                    t3_d       = 1'b0;
                    done_d     = 1'b1;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                t2_d    = 1'b0;
                t3_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge C_clk) begin
        if (C_rst) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            gap_m1_q <= 16'd0;
            t1_q     <= 1'b0;
            t2_q     <= 1'b0;
            t3_q     <= 1'b1;
            t4_q     <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_m1_q <= gap_m1_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            t3_q     <= t3_d;
            t4_q     <= t4_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign DA_test1 = t1_q;
    assign DA_test2 = t2_q;
    assign DA_test3 = t3_q;
    assign DA_test4 = t4_q;
    assign C_busy   = busy_q;
    assign C_done   = done_q;

`ifdef PMU_SEQ_STATS_EN
    logic [15:0] seq_cnt_q;

    always_ff @(posedge C_clk) begin
        if (C_rst) begin
            seq_cnt_q <= 16'd0;
        end else if (enter_done && (seq_cnt_q != 16'hFFFF)) begin
            seq_cnt_q <= seq_cnt_q + 16'd1;
        end
    end

    assign C_seq_cnt = seq_cnt_q;
`endif

endmodule

// File: tb/tb_pmu_seq_gen.sv
// Bench for pmu_seq_gen: offset-based sequence model checked every cycle, plus measured widths against literals.
module tb_pmu_seq_gen;

    localparam int MIN_P = 1001;
    localparam int MIN_G = 3;

    logic        C_clk = 1'b0;
    logic        C_rst = 1'b0;
    logic        C_start = 1'b0;
    logic [15:0] C_pulse_len = 16'd0;
    logic [7:0]  C_gap_len = 8'd0;
    logic [3:0]  C_code = 4'd0;
    logic        DA_test1, DA_test2, DA_test3, C_busy, C_done;
    logic [3:0]  DA_test4;
`ifdef PMU_SEQ_STATS_EN
    logic [15:0] C_seq_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    pmu_seq_gen #(.MIN_PULSE_CYC(MIN_P), .MIN_GAP_CYC(MIN_G)) dut (
        .C_clk(C_clk),
        .C_rst(C_rst),
        .C_start(C_start),
        .C_pulse_len(C_pulse_len),
        .C_gap_len(C_gap_len),
        .C_code(C_code),
        .DA_test1(DA_test1),
        .DA_test2(DA_test2),
        .DA_test3(DA_test3),
        .DA_test4(DA_test4),
        .C_busy(C_busy),
        .C_done(C_done)
`ifdef PMU_SEQ_STATS_EN
        ,
        .C_seq_cnt(C_seq_cnt)
`endif
    );

    always #5 C_clk = ~C_clk;

    // Model: a sequence occupies edge offsets 0..N+G+1 after the accepting edge.
    bit m_valid = 0;
    bit m_act = 0;
    int m_j = 0, m_n = 0, m_g = 0, m_code = 0, m_seq = 0;

    // Measurements over the sampled waveforms.
    int pw_run = 0, last_pw = 0, gap_run = 0, last_gap = 0;
    int done_cnt = 0, idle_run = 0, last_idle = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge C_clk) begin
        logic [8:0] exp_v, got_v;
        if (C_rst) begin
            m_valid = 1;
            m_act   = 0;
            m_code  = 0;
            m_seq   = 0;
        end else if (!m_act) begin
            if (C_start) begin
                m_act  = 1;
                m_j    = 0;
                m_n    = (int'(C_pulse_len) > MIN_P) ? int'(C_pulse_len) : MIN_P;
                m_g    = (int'(C_gap_len) > MIN_G) ? int'(C_gap_len) : MIN_G;
                m_code = int'(C_code);
            end
        end else begin
            m_j++;
            if (m_j == m_n + m_g + 1) m_act = 0;
        end
        if (m_act && m_j == m_n + m_g && m_seq < 65535) m_seq++;
        #1;
        if (m_valid) begin
            exp_v = {m_act && (m_j < m_n),
                     m_act && (m_j >= m_n) && (m_j <= m_n + m_g),
                     !(m_act && (m_j == m_n + m_g)),
                     4'(m_code),
                     m_act,
                     m_act && (m_j == m_n + m_g)};
            got_v = {DA_test1, DA_test2, DA_test3, DA_test4, C_busy, C_done};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: got {t1,t2,t3,t4,busy,done}=%b, expected %b", $time, got_v, exp_v);
            end
`ifdef PMU_SEQ_STATS_EN
            n_cmp++;
            if (int'(C_seq_cnt) != m_seq) begin
                n_fail++;
                $display("FAIL seq_cnt_cmp t=%0t: got %0d, expected %0d", $time, C_seq_cnt, m_seq);
            end
`endif
        end
        if (DA_test1) pw_run++;
        else if (pw_run != 0) begin last_pw = pw_run; pw_run = 0; end
        if (DA_test2 && DA_test3) gap_run++;
        else if (gap_run != 0) begin last_gap = gap_run; gap_run = 0; end
        if (C_done) done_cnt++;
        if (!C_busy) idle_run++;
        else begin
            if (idle_run != 0) last_idle = idle_run;
            idle_run = 0;
        end
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge C_clk);
            if (C_done) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask

    task automatic start_seq(input int pl, input int gl, input int code);
        @(negedge C_clk);
        C_pulse_len = 16'(pl);
        C_gap_len   = 8'(gl);
        C_code      = 4'(code);
        C_start     = 1'b1;
        @(negedge C_clk);
        C_start     = 1'b0;
    endtask

    initial begin
        // Reset state
        C_rst = 1'b1;
        repeat (2) @(negedge C_clk);
        C_rst = 1'b0;
        check("rst_t1", int'(DA_test1), 0);
        check("rst_t2", int'(DA_test2), 0);
        check("rst_t3", int'(DA_test3), 1);
        check("rst_t4", int'(DA_test4), 0);
        check("rst_busy", int'(C_busy), 0);
        check("rst_done", int'(C_done), 0);

        // Nominal sequence
        done_cnt = 0;
        start_seq(2000, 5, 'hA);
        wait_done("nom");
        repeat (3) @(negedge C_clk);
        check("nom_pw", last_pw, 2000);
        check("nom_gap", last_gap, 5);
        check("nom_done", done_cnt, 1);
        check("nom_code", int'(DA_test4), 'hA);

        // Clamped to minima
        start_seq(10, 0, 3);
        wait_done("clamp");
        repeat (3) @(negedge C_clk);
        check("clamp_pw", last_pw, 1001);
        check("clamp_gap", last_gap, 3);

        // Start and config changes while busy are ignored
        done_cnt = 0;
        start_seq(1200, 4, 5);
        repeat (300) @(negedge C_clk);
        C_start = 1'b1; C_code = 4'hF; C_pulse_len = 16'd10; C_gap_len = 8'd50;
        @(negedge C_clk);
        C_start = 1'b0;
        wait_done("busy");
        repeat (6) @(negedge C_clk);
        check("busy_pw", last_pw, 1200);
        check("busy_gap", last_gap, 4);
        check("busy_done", done_cnt, 1);
        check("busy_code", int'(DA_test4), 5);
        check("busy_idle", int'(C_busy), 0);

        // Back-to-back with C_start held high
        done_cnt = 0;
        C_pulse_len = 16'd0; C_gap_len = 8'd0; C_code = 4'h7; C_start = 1'b1;
        wait_done("b2b1");
        wait_done("b2b2");
        C_start = 1'b0;
        repeat (3) @(negedge C_clk);
        check("b2b_done", done_cnt, 2);
        check("b2b_idle_gap", last_idle, 1);
        check("b2b_code", int'(DA_test4), 7);
`ifdef PMU_SEQ_STATS_EN
        check("stats_five", int'(C_seq_cnt), 5);
`endif

        // Reset at cycle 500 of PULSE
        start_seq(2000, 5, 'hC);
        repeat (499) @(negedge C_clk);
        check("pre_rst_t1", int'(DA_test1), 1);
        C_rst = 1'b1;
        C_start = 1'b1;
        @(negedge C_clk);
        C_rst = 1'b0;
        C_start = 1'b0;
        check("midrst_t1", int'(DA_test1), 0);
        check("midrst_t3", int'(DA_test3), 1);
        check("midrst_busy", int'(C_busy), 0);
        check("midrst_t4", int'(DA_test4), 0);
        check("midrst_pw", last_pw, 500);

        // Three full sequences after reset
        for (int s = 0; s < 3; s++) begin
            start_seq(0, 0, 9 + s);
            wait_done("post");
            repeat (2) @(negedge C_clk);
            check("post_pw", last_pw, 1001);
            check("post_gap", last_gap, 3);
        end
        check("post_code", int'(DA_test4), 11);
`ifdef PMU_SEQ_STATS_EN
        check("stats_three", int'(C_seq_cnt), 3);
`endif

        repeat (2) @(negedge C_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pmu_seq_gen.md
PMU_SEQ_GEN -- requirements
Module: pmu_seq_gen

Interface
REQ-001 SHALL have parameter MIN_PULSE_CYC, default 1001, minimum DA_test1 high width in clock cycles (>10us at 100MHz).
REQ-002 SHALL have parameter MIN_GAP_CYC, default 3, minimum cycles from DA_test2 rise to DA_test3 fall (>20ns at 100MHz).
REQ-003 SHALL have port C_clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port C_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port C_start, input, 1, sequence request, sampled in IDLE only.
REQ-006 SHALL have port C_pulse_len, input, 16, requested DA_test1 high width in cycles.
REQ-007 SHALL have port C_gap_len, input, 8, requested DA_test2-rise to DA_test3-fall spacing in cycles.
REQ-008 SHALL have port C_code, input, 4, trim code presented on DA_test4.
REQ-009 SHALL have ports DA_test1, DA_test2 and DA_test3, each output, 1, registered PMU control lines.
REQ-010 SHALL have port DA_test4, output, 4, registered trim code.
REQ-011 SHALL have port C_busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port C_done, output, 1, one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, PULSE, GAP and DONE, with all outputs driven from registers.
REQ-014 IDLE: when C_start=1 at an edge, SHALL latch C_pulse_len, C_gap_len and C_code, set DA_test4 to C_code and DA_test1 to 1, and enter PULSE at that same edge.
REQ-015 SHALL use effective width N = max(latched C_pulse_len, MIN_PULSE_CYC); C_pulse_len=0 SHALL yield MIN_PULSE_CYC.
REQ-016 PULSE: DA_test1 SHALL stay high for exactly N cycles; at the Nth edge DA_test1 SHALL go 0, DA_test2 SHALL go 1 and the FSM SHALL enter GAP.
REQ-017 SHALL use effective gap G = max(latched C_gap_len, MIN_GAP_CYC).
REQ-018 GAP: DA_test3 SHALL remain 1 for exactly G cycles after the DA_test2 rise; at the Gth edge DA_test3 SHALL go 0 and the FSM SHALL enter DONE.
REQ-019 DONE: C_done SHALL be 1 for exactly one cycle; the next edge SHALL set DA_test2=0 and DA_test3=1 and enter IDLE.
REQ-020 DA_test3 SHALL never be 0 at an edge where DA_test2 rises.
REQ-021 DA_test4 SHALL hold the latched code until the next accepted C_start.
REQ-022 C_start outside IDLE SHALL be ignored; latched configuration SHALL be immune to input changes while busy.
REQ-023 C_start held high SHALL start a new sequence on the first IDLE cycle after DONE (back-to-back).
REQ-024 Counters SHALL be 16 bits wide, load with effective value minus 1, decrement to 0 and never wrap.

Reset
REQ-025 With C_rst=1 at an edge, the following SHALL apply at that edge regardless of state: state=IDLE, DA_test1=0, DA_test2=0, DA_test3=1, DA_test4=0, C_busy=0, C_done=0, counters=0.
REQ-026 Reset mid-PULSE SHALL truncate the pulse and is the only permitted width violation; C_rst SHALL take priority over C_start.

Configuration
REQ-027 With macro PMU_SEQ_STATS_EN defined, SHALL add output C_seq_cnt (16 bits), incremented on each DONE and saturating at 0xFFFF, reset to 0.
REQ-028 Without PMU_SEQ_STATS_EN, the C_seq_cnt port and counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, C_start=1, C_pulse_len=2000, C_gap_len=5, C_code=4'hA -> DA_test4=A, DA_test1 high 2000 cycles, DA_test3 falls 5 cycles after DA_test2 rise, C_done pulses once.
REQ-030 C_pulse_len=10, C_gap_len=0 -> DA_test1 high 1001 cycles, gap 3 cycles (clamps).
REQ-031 C_start pulsed during PULSE and C_code changed -> no restart, DA_test4 unchanged, single C_done.
REQ-032 C_start held high -> consecutive sequences, C_busy low for exactly one cycle between them.
REQ-033 C_rst asserted at cycle 500 of PULSE -> at that edge DA_test1=0, DA_test3=1, C_busy=0; next C_start runs a full sequence.
REQ-034 With PMU_SEQ_STATS_EN, 3 sequences -> C_seq_cnt=3; bench-bound pulse-width/gap assertions report zero failures.
